// File: rtl/mlp_loop_seq.sv
// Run-time-bounded (q, n, i) nested-loop index sequencer for the MLP datapath.
// A start/busy/done handshake frames each job; stall holds the stream and abort cancels it.
module mlp_loop_seq #(
  parameter int QW = 4,
  parameter int NW = 8,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [QW-1:0] q_max,
  input  logic [NW-1:0] n_max,
  input  logic [IW-1:0] i_max,
  input  logic          stall,
  input  logic          abort,
  output logic [QW-1:0] q,
  output logic [NW-1:0] n,
  output logic [IW-1:0] i,
  output logic          valid,
  output logic          q_first,
  output logic          q_last,
  output logic          n_last,
  output logic          i_last,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [QW-1:0] q_reg, q_next, q_max_reg, q_max_next;
  logic [NW-1:0] n_reg, n_next, n_max_reg, n_max_next;
  logic [IW-1:0] i_reg, i_next, i_max_reg, i_max_next;
  logic          err_reg, err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      q_reg     <= QW'(1);
      n_reg     <= NW'(1);
      i_reg     <= IW'(1);
      q_max_reg <= '0;
      n_max_reg <= '0;
      i_max_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      n_reg     <= n_next;
      i_reg     <= i_next;
      q_max_reg <= q_max_next;
      n_max_reg <= n_max_next;
      i_max_reg <= i_max_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    n_next     = n_reg;
    i_next     = i_reg;
    q_max_next = q_max_reg;
    n_max_next = n_max_reg;
    i_max_next = i_max_reg;
    err_next   = 1'b0;
    if (abort) begin
      state_next = IDLE;
      q_next     = QW'(1);
      n_next     = NW'(1);
      i_next     = IW'(1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (q_max != '0 && n_max != '0 && i_max != '0) begin
              q_max_next = q_max;
              n_max_next = n_max;
              i_max_next = i_max;
              q_next     = QW'(1);
              n_next     = NW'(1);
              i_next     = IW'(1);
              state_next = RUN;
            end else begin
              err_next = 1'b1;
            end
          end
        end
        RUN: begin
          // Equality compares keep every index within its bound at full width.
          if (!stall) begin
            if (q_reg != q_max_reg) begin
              q_next = q_reg + QW'(1);
            end else begin
              q_next = QW'(1);
              if (n_reg != n_max_reg) begin
                n_next = n_reg + NW'(1);
              end else begin
                n_next = NW'(1);
                if (i_reg != i_max_reg) begin
                  i_next = i_reg + IW'(1);
                end else begin
                  i_next     = IW'(1);
                  state_next = DONE;
                end
              end
            end
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign q       = q_reg;
  assign n       = n_reg;
  assign i       = i_reg;
  assign valid   = (state_reg == RUN);
  assign busy    = (state_reg == RUN);
  assign done    = (state_reg == DONE);
  assign err     = err_reg;
  assign q_first = valid && (q_reg == QW'(1));
  assign q_last  = valid && (q_reg == q_max_reg);
  assign n_last  = valid && (n_reg == n_max_reg);
  assign i_last  = valid && (i_reg == i_max_reg);

endmodule

// File: tb/tb_mlp_loop_seq.sv
// Self-checking bench for mlp_loop_seq: directed and randomized jobs compared against
// an expected tuple list built from plain nested loops over the job bounds.
module tb_mlp_loop_seq;

  logic       clk = 1'b0;
  logic       rst, start, stall, abort;
  logic [3:0] q_max, i_max;
  logic [7:0] n_max;
  logic [3:0] q, i;
  logic [7:0] n;
  logic       valid, q_first, q_last, n_last, i_last, busy, done, err;

  int checks = 0;
  int errors = 0;

  typedef struct {int q; int n; int i;} tup_t;
  tup_t exp_q[$];

  mlp_loop_seq #(.QW(4), .NW(8), .IW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .q_max(q_max), .n_max(n_max), .i_max(i_max),
    .stall(stall), .abort(abort), .q(q), .n(n), .i(i), .valid(valid),
    .q_first(q_first), .q_last(q_last), .n_last(n_last), .i_last(i_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {valid,busy,done,err,q_first,q_last,n_last,i_last,q,n,i}
  function automatic logic [23:0] obs_vec();
    return {valid, busy, done, err, q_first, q_last, n_last, i_last, q, n, i};
  endfunction

  function automatic logic [23:0] run_vec(tup_t t, int qm, int nm, int im);
    return {1'b1, 1'b1, 1'b0, 1'b0, t.q == 1, t.q == qm, t.n == nm, t.i == im,
            4'(t.q), 8'(t.n), 4'(t.i)};
  endfunction

  function automatic logic [23:0] idle_vec(logic d, logic e);
    return {1'b0, 1'b0, d, e, 4'b0000, 4'd1, 8'd1, 4'd1};
  endfunction

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build(int qm, int nm, int im);
    exp_q.delete();
    for (int ii = 1; ii <= im; ii++)
      for (int nn = 1; nn <= nm; nn++)
        for (int qq = 1; qq <= qm; qq++)
          exp_q.push_back('{q: qq, n: nn, i: ii});
  endtask

  // smode: 0 none, 1 random, 2 three stalls on tuple index 4. mid_start pulses start during RUN.
  task automatic run_job(string name, int qm, int nm, int im, int smode, bit mid_start);
    int idx = 0, stalls = 0, cycles, limit, hold = 0;
    bit s;
    build(qm, nm, im);
    limit = 4 * exp_q.size() + 100;
    start = 1'b1; q_max = 4'(qm); n_max = 8'(nm); i_max = 4'(im);
    tick();
    cycles = 1;
    start = 1'b0;
    while (idx < exp_q.size() && cycles < limit) begin
      check({name, "_tuple"}, {8'h0, obs_vec()}, {8'h0, run_vec(exp_q[idx], qm, nm, im)});
      case (smode)
        1:       s = ($urandom_range(0, 3) == 0);
        2:       s = (idx == 4 && hold < 3);
        default: s = 1'b0;
      endcase
      if (s && smode == 2) hold++;
      stall = s;
      start = mid_start && ($urandom_range(0, 7) == 0);
      q_max = 4'($urandom); n_max = 8'($urandom); i_max = 4'($urandom);
      tick();
      cycles++;
      if (s) stalls++;
      else idx++;
    end
    stall = 1'b0;
    start = 1'b0;
    check({name, "_finished"}, idx, exp_q.size());
    check({name, "_done"}, {8'h0, obs_vec()}, {8'h0, idle_vec(1'b1, 1'b0)});
    check({name, "_latency"}, cycles, exp_q.size() + stalls + 1);
    if (smode == 2) check({name, "_stall_cnt"}, stalls, 3);
    tick();
    check({name, "_idle"}, {8'h0, obs_vec()}, {8'h0, idle_vec(1'b0, 1'b0)});
    $display("job %s %0d/%0d/%0d cycles=%0d stalls=%0d", name, qm, nm, im, cycles, stalls);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; abort = 1'b0;
    q_max = 4'd0; n_max = 8'd0; i_max = 4'd0;
    tick(); tick();
    rst = 1'b0;
    check("reset", {8'h0, obs_vec()}, {8'h0, idle_vec(1'b0, 1'b0)});

    run_job("b232", 2, 3, 2, 0, 1'b0);
    run_job("legacy", 8, 200, 10, 0, 1'b0);
    run_job("stall321", 3, 2, 1, 2, 1'b0);

    // zero bound rejected
    start = 1'b1; q_max = 4'd2; n_max = 8'd0; i_max = 4'd2;
    tick();
    start = 1'b0;
    check("err_pulse", {8'h0, obs_vec()}, {8'h0, idle_vec(1'b0, 1'b1)});
    tick();
    check("err_clear", {8'h0, obs_vec()}, {8'h0, idle_vec(1'b0, 1'b0)});
    $display("err test done");

    // abort at (1,2,1) of a 4/4/4 job
    build(4, 4, 4);
    start = 1'b1; q_max = 4'd4; n_max = 8'd4; i_max = 4'd4;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("abort_at", {8'h0, obs_vec()}, {8'h0, run_vec(exp_q[4], 4, 4, 4)});
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_idle", {8'h0, obs_vec()}, {8'h0, idle_vec(1'b0, 1'b0)});
    tick(); tick();
    check("abort_nodone", {8'h0, obs_vec()}, {8'h0, idle_vec(1'b0, 1'b0)});
    $display("abort test done");
    run_job("single", 1, 1, 1, 0, 1'b0);

    // start pulsed mid-run is ignored
    run_job("midstart", 3, 4, 2, 0, 1'b1);

    // rst mid-run
    start = 1'b1; q_max = 4'd2; n_max = 8'd3; i_max = 4'd2;
    tick();
    start = 1'b0;
    for (int k = 0; k < $urandom_range(1, 10); k++) tick();
    check("rst_run", 32'(valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid", {8'h0, obs_vec()}, {8'h0, idle_vec(1'b0, 1'b0)});
    $display("rst test done");

    // randomized jobs with random stall and ignored mid-run starts
    for (int k = 0; k < 8; k++)
      run_job("rand", $urandom_range(1, 15), $urandom_range(1, 6), $urandom_range(1, 4), 1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
